// File: rtl/reset_request_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : reset_pkg                                                    |
// | Description : Shared state and reset-cause encodings for reset_request_ctrl|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package reset_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  // Width of the shared pulse/holdoff down-counter.
  function automatic int unsigned phase_cnt_width(input int unsigned pulse,
                                                  input int unsigned holdoff);
    int unsigned longest;
    longest = (pulse > holdoff) ? pulse : holdoff;
    return $clog2(longest + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_request_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module      : reset_request_ctrl_if                                        |
// | Description : Request, watchdog and status signals of reset_request_ctrl   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface reset_request_ctrl_if
  import reset_pkg::*;
#(
  parameter int WDT_WIDTH = 24
);

  logic                 sw_rst_req;
  logic                 wdt_en;
  logic                 wdt_kick;
  logic [WDT_WIDTH-1:0] wdt_timeout;
  logic                 sys_ready;
  logic                 cause_clr;
  logic                 rst_req_n;
  logic [1:0]           rst_cause;
  logic [WDT_WIDTH-1:0] wdt_count;
  logic                 busy;

  modport master (
    output sw_rst_req, wdt_en, wdt_kick, wdt_timeout, sys_ready, cause_clr,
    input  rst_req_n, rst_cause, wdt_count, busy
  );

  modport slave (
    input  sw_rst_req, wdt_en, wdt_kick, wdt_timeout, sys_ready, cause_clr,
    output rst_req_n, rst_cause, wdt_count, busy
  );

endinterface

`default_nettype wire

// File: rtl/reset_request_ctrl_wdt_counter.sv
// +----------------------------------------------------------------------------+
// | Module      : wdt_counter                                                  |
// | Description : Watchdog down-counter with load/kick and expiry strobe       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module wdt_counter
  import reset_pkg::*;
#(
  parameter int WDT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 kick,
  input  logic [WDT_WIDTH-1:0] load_value,
  input  logic                 run,
  output logic [WDT_WIDTH-1:0] count,
  output logic                 expire
);

  localparam logic [WDT_WIDTH-1:0] c_zero = '0;
  localparam logic [WDT_WIDTH-1:0] c_one  = {{(WDT_WIDTH-1){1'b0}}, 1'b1};

  logic                 r_en_d;
  logic [WDT_WIDTH-1:0] r_count;
  logic                 w_load;
  logic [WDT_WIDTH-1:0] w_load_value;

  assign w_load       = en & (~r_en_d | kick);
  assign w_load_value = (load_value == c_zero) ? c_one : load_value;

  // A reload in the expiry cycle suppresses the trigger.
  assign expire = en & run & (r_count == c_one) & ~w_load;
  assign count  = r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en_d  <= 1'b0;
      r_count <= c_zero;
    end else begin
      r_en_d <= en;
      if (!en) begin
        r_count <= c_zero;
      end else if (w_load) begin
        r_count <= w_load_value;
      end else if (run && (r_count != c_zero)) begin
        r_count <= r_count - c_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reset_request_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : reset_request_ctrl                                           |
// | Description : Stretched reset request pulse with sticky reset-cause record |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module reset_request_ctrl
  import reset_pkg::*;
#(
  parameter int WDT_WIDTH      = 24,
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  reset_request_ctrl_if.slave  bus
);

  localparam int CNT_W = phase_cnt_width(PULSE_CYCLES, HOLDOFF_CYCLES);

  localparam logic [CNT_W-1:0] c_cnt_zero   = '0;
  localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_pulse_load = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_hold_load  = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_req_n;
  logic                 r_busy;
  logic [1:0]           r_cause;

  logic                 w_idle;
  logic                 w_expire;
  logic                 w_sw_trig;
  logic                 w_wdt_trig;
  logic                 w_trigger;
  logic [WDT_WIDTH-1:0] w_count;

  assign w_idle     = (r_state == IDLE);
  assign w_sw_trig  = w_idle & bus.sw_rst_req;
  assign w_wdt_trig = w_idle & w_expire;
  assign w_trigger  = w_sw_trig | w_wdt_trig;

  // The watchdog only runs while the system is up and no request is in flight.
  wdt_counter #(
    .WDT_WIDTH (WDT_WIDTH)
  ) u_wdt (
    .clk        (clk),
    .rstn       (rstn),
    .en         (bus.wdt_en),
    .kick       (bus.wdt_kick),
    .load_value (bus.wdt_timeout),
    .run        (bus.sys_ready & w_idle),
    .count      (w_count),
    .expire     (w_expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= c_cnt_zero;
      r_req_n <= 1'b1;
      r_busy  <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_state <= ASSERT;
            r_cnt   <= c_pulse_load;
            r_req_n <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ASSERT: begin
          if (r_cnt == c_cnt_zero) begin
            r_state <= HOLDOFF;
            r_cnt   <= c_hold_load;
            r_req_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        HOLDOFF: begin
          // Holdoff expiry alone is not enough; wait for the system to come back.
          if (r_cnt == c_cnt_zero) begin
            if (bus.sys_ready) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= c_cnt_zero;
          r_req_n <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_trigger) begin
        r_cause <= {w_wdt_trig, w_sw_trig};
      end else if (bus.cause_clr) begin
        r_cause <= CAUSE_NONE;
      end
    end
  end

  assign bus.rst_req_n = r_req_n;
  assign bus.busy      = r_busy;
  assign bus.rst_cause = r_cause;
  assign bus.wdt_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_reset_request_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_reset_request_ctrl                                        |
// | Description : Self-checking bench for reset_request_ctrl                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reset_request_ctrl;
  import reset_pkg::*;

  localparam int WDT_WIDTH      = 24;
  localparam int PULSE_CYCLES   = 16;
  localparam int HOLDOFF_CYCLES = 8;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;

  reset_request_ctrl_if #(.WDT_WIDTH(WDT_WIDTH)) bus ();

  reset_request_ctrl #(
    .WDT_WIDTH      (WDT_WIDTH),
    .PULSE_CYCLES   (PULSE_CYCLES),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: request timeline as remaining low cycles plus holdoff age.
  int         m_low_left;
  bit         m_hold;
  int         m_hold_done;
  int         m_count;
  bit         m_en_prev;
  logic [1:0] m_cause;

  function automatic void model_reset();
    m_low_left  = 0;
    m_hold      = 1'b0;
    m_hold_done = 0;
    m_count     = 0;
    m_en_prev   = 1'b0;
    m_cause     = 2'b00;
  endfunction

  function automatic void model_step();
    bit idle     = (m_low_left == 0) && !m_hold;
    bit load     = bus.wdt_en && (!m_en_prev || bus.wdt_kick);
    int loadv    = (bus.wdt_timeout == 0) ? 1 : int'(bus.wdt_timeout);
    bit wdt_fire = idle && bus.wdt_en && bus.sys_ready && (m_count == 1) && !load;
    bit sw_fire  = idle && bus.sw_rst_req;
    if (!bus.wdt_en) m_count = 0;
    else if (load) m_count = loadv;
    else if (idle && bus.sys_ready && m_count > 0) m_count = m_count - 1;
    m_en_prev = bus.wdt_en;
    if (sw_fire || wdt_fire) m_cause = {wdt_fire, sw_fire};
    else if (bus.cause_clr) m_cause = 2'b00;
    if (sw_fire || wdt_fire) begin
      m_low_left = PULSE_CYCLES;
    end else if (m_low_left > 0) begin
      m_low_left = m_low_left - 1;
      if (m_low_left == 0) begin
        m_hold      = 1'b1;
        m_hold_done = 0;
      end
    end else if (m_hold) begin
      m_hold_done = m_hold_done + 1;
      if (m_hold_done >= HOLDOFF_CYCLES && bus.sys_ready) m_hold = 1'b0;
    end
  endfunction

  function automatic logic [27:0] model_vec();
    return {(m_low_left == 0), ((m_low_left > 0) || m_hold), m_cause,
            WDT_WIDTH'(m_count)};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {bus.rst_req_n, bus.busy, bus.rst_cause, bus.wdt_count};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rstn) model_step();
    else model_reset();
    #1;
  endtask

  task automatic idle_inputs();
    bus.sw_rst_req  = 1'b0;
    bus.wdt_en      = 1'b0;
    bus.wdt_kick    = 1'b0;
    bus.wdt_timeout = '0;
    bus.sys_ready   = 1'b1;
    bus.cause_clr   = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    bus.sys_ready = 1'b1;
    while (bus.busy !== 1'b0 && guard < 100) begin
      cycle();
      guard++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL wait_idle: busy=%0b required 0 within 100 cycles", bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sw_rst_req  = 1'($urandom);
      bus.wdt_en      = 1'($urandom);
      bus.wdt_kick    = 1'($urandom);
      bus.wdt_timeout = WDT_WIDTH'($urandom_range(0, 5));
      bus.sys_ready   = 1'($urandom);
      bus.cause_clr   = 1'($urandom);
      cycle();
      n_checks++;
      if (dut_vec() !== 28'h8000000)
        $display("FAIL reset_state: got %h required %h", dut_vec(), 28'h8000000);
      else n_pass++;
    end
    idle_inputs();
    rstn = 1'b1;
    cycle();
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL reset_release: got %h required %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_sw_request();
    int low = 0;
    wait_idle();
    bus.sw_rst_req = 1'b1;
    cycle();
    bus.sw_rst_req = 1'b0;
    bus.sys_ready  = 1'b0;
    for (int t = 0; t <= 30; t++) begin
      if (t > 0) cycle();
      if (bus.rst_req_n === 1'b0) low++;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.rst_req_n !== (t >= PULSE_CYCLES))
        $display("FAIL sw_pulse t=%0d: busy=%0b req_n=%0b required busy=1 req_n=%0b",
                 t, bus.busy, bus.rst_req_n, (t >= PULSE_CYCLES));
      else n_pass++;
    end
    n_checks++;
    if (low != PULSE_CYCLES) $display("FAIL sw_pulse_len: got %0d required %0d", low, PULSE_CYCLES);
    else n_pass++;
    bus.sys_ready = 1'b1;
    cycle();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rst_cause !== CAUSE_SW)
      $display("FAIL sw_release: busy=%0b cause=%b required busy=0 cause=01", bus.busy, bus.rst_cause);
    else n_pass++;
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL sw_model: got %h required %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int n = 0;
    wait_idle();
    bus.wdt_timeout = WDT_WIDTH'(10);
    bus.wdt_en      = 1'b1;
    cycle();
    n_checks++;
    if (bus.wdt_count !== WDT_WIDTH'(10)) $display("FAIL wdt_load: got %0d required 10", bus.wdt_count);
    else n_pass++;
    while (bus.rst_req_n === 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    n_checks++;
    if (n != 10 || bus.rst_req_n !== 1'b0 || bus.rst_cause !== CAUSE_WDT || bus.wdt_count !== '0)
      $display("FAIL wdt_expiry: decrements=%0d req_n=%0b cause=%b count=%0d required 10/0/10/0",
               n, bus.rst_req_n, bus.rst_cause, bus.wdt_count);
    else n_pass++;
    wait_idle();
    n_checks++;
    if (dut_vec() !== model_vec() || bus.wdt_count !== '0)
      $display("FAIL wdt_after: got %h required %h", dut_vec(), model_vec());
    else n_pass++;
    bus.wdt_en = 1'b0;
    cycle();
  endtask

  task automatic test_kick_race();
    int bad = 0;
    wait_idle();
    bus.wdt_timeout = WDT_WIDTH'(4);
    bus.wdt_en      = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (bus.wdt_count !== WDT_WIDTH'(1)) $display("FAIL kick_pre: count=%0d required 1", bus.wdt_count);
    else n_pass++;
    bus.wdt_kick = 1'b1;
    cycle();
    bus.wdt_kick = 1'b0;
    n_checks++;
    if (bus.wdt_count !== WDT_WIDTH'(4) || bus.rst_req_n !== 1'b1)
      $display("FAIL kick_race: count=%0d req_n=%0b required 4/1", bus.wdt_count, bus.rst_req_n);
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      bus.wdt_kick = (i % 3 == 2);
      cycle();
      if (bus.rst_req_n !== 1'b1 || dut_vec() !== model_vec()) bad++;
    end
    bus.wdt_kick = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL kick_repeat: bad cycles=%0d required 0", bad);
    else n_pass++;
    bus.wdt_en = 1'b0;
    cycle();
  endtask

  task automatic test_simultaneous();
    int low = 1;
    wait_idle();
    bus.wdt_timeout = WDT_WIDTH'(3);
    bus.wdt_en      = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    bus.sw_rst_req = 1'b1;
    cycle();
    bus.sw_rst_req = 1'b0;
    n_checks++;
    if (bus.rst_req_n !== 1'b0 || bus.rst_cause !== CAUSE_BOTH)
      $display("FAIL both_cause: req_n=%0b cause=%b required 0/11", bus.rst_req_n, bus.rst_cause);
    else n_pass++;
    for (int i = 0; i < 30 && bus.rst_req_n === 1'b0; i++) begin
      cycle();
      if (bus.rst_req_n === 1'b0) low++;
    end
    n_checks++;
    if (low != PULSE_CYCLES) $display("FAIL both_pulse_len: got %0d required %0d", low, PULSE_CYCLES);
    else n_pass++;
    bus.sw_rst_req = 1'b1;
    cycle();
    bus.sw_rst_req = 1'b0;
    cycle();
    n_checks++;
    if (bus.rst_cause !== CAUSE_BOTH || bus.rst_req_n !== 1'b1)
      $display("FAIL holdoff_ignore: cause=%b req_n=%0b required 11/1", bus.rst_cause, bus.rst_req_n);
    else n_pass++;
    bus.cause_clr = 1'b1;
    cycle();
    bus.cause_clr = 1'b0;
    n_checks++;
    if (bus.rst_cause !== CAUSE_NONE) $display("FAIL cause_clr: got %b required 00", bus.rst_cause);
    else n_pass++;
    bus.wdt_en = 1'b0;
    wait_idle();
  endtask

  task automatic test_mid_pulse_reset();
    int bad = 0;
    wait_idle();
    bus.sw_rst_req = 1'b1;
    cycle();
    bus.sw_rst_req = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.rst_req_n !== 1'b1 || bus.busy !== 1'b0 || bus.rst_cause !== CAUSE_NONE)
      $display("FAIL async_abort: req_n=%0b busy=%0b cause=%b required 1/0/00",
               bus.rst_req_n, bus.busy, bus.rst_cause);
    else n_pass++;
    model_reset();
    cycle();
    cycle();
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (bus.rst_req_n !== 1'b1 || dut_vec() !== model_vec()) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL residual_pulse: bad cycles=%0d required 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.sw_rst_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) bus.wdt_en = ~bus.wdt_en;
      bus.wdt_kick    = ($urandom_range(0, 7) == 0);
      bus.wdt_timeout = WDT_WIDTH'($urandom_range(0, 7));
      bus.sys_ready   = ($urandom_range(0, 9) != 0);
      bus.cause_clr   = ($urandom_range(0, 14) == 0);
      cycle();
      n_checks++;
      if (dut_vec() !== model_vec())
        $display("FAIL random cyc=%0d: got %h required %h", i, dut_vec(), model_vec());
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_sw_request();
    test_watchdog();
    test_kick_race();
    test_simultaneous();
    test_mid_pulse_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
